// File: rtl/fault_cls_pkg.sv
// Shared types and default sizing for the fault-class confirmation stage.
package fault_cls_pkg;

   // Default class-code geometry matching the upstream decision-tree classifier.
   localparam int C_DEF          = 3;
   localparam int NUM_CLS_DEF    = 6;
   localparam int NORMAL_CLS_DEF = 0;

   // Debounce FSM states.
   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      CONFIRMED,
      RELEASE
   } state_t;

   // Event record as delivered to the protection controller (default code width).
   typedef struct packed {
      logic              set;
      logic [C_DEF-1:0]  cls;
   } evt_t;

endpackage

// File: rtl/fault_evt_slot.sv
// Single-entry event holding register with valid/ready handshake.
// A new push overwrites any held event; overwriting an event that is not
// being accepted in the same cycle sets a sticky overrun flag.
module fault_evt_slot
   import fault_cls_pkg::*;
#(
   parameter int C          = C_DEF,
   parameter int NORMAL_CLS = NORMAL_CLS_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         push_set,
   input  logic [C-1:0] push_cls,
   input  logic         evt_ready,
   output logic         evt_valid,
   output logic         evt_set,
   output logic [C-1:0] evt_cls,
   output logic         evt_overrun
);

   localparam logic [C-1:0] NORM = NORMAL_CLS[C-1:0];

   logic         valid_q, valid_d;
   logic         set_q, set_d;
   logic [C-1:0] cls_q, cls_d;
   logic         overrun_q, overrun_d;

   // Next-state for the slot: push beats acceptance, acceptance empties the slot.
   always_comb begin
      valid_d   = valid_q;
      set_d     = set_q;
      cls_d     = cls_q;
      overrun_d = overrun_q;
      if (push) begin
         valid_d = 1'b1;
         set_d   = push_set;
         cls_d   = push_cls;
         if (valid_q && !evt_ready) begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && evt_ready) begin
         valid_d = 1'b0;
      end
   end

   // Slot registers; payload stays stable while valid and not accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         set_q     <= 1'b0;
         cls_q     <= NORM;
         overrun_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         set_q     <= set_d;
         cls_q     <= cls_d;
         overrun_q <= overrun_d;
      end
   end

   assign evt_valid   = valid_q;
   assign evt_set     = set_q;
   assign evt_cls     = cls_q;
   assign evt_overrun = overrun_q;

endmodule

// File: rtl/fault_cls_confirm.sv
// Debounces classifier class codes: confirms a fault after CONFIRM_N identical
// fault samples and clears it after RELEASE_N consecutive normal samples.
module fault_cls_confirm
   import fault_cls_pkg::*;
#(
   parameter int C          = C_DEF,
   parameter int NUM_CLS    = NUM_CLS_DEF,
   parameter int NORMAL_CLS = NORMAL_CLS_DEF,
   parameter int CONFIRM_N  = 4,
   parameter int RELEASE_N  = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [C-1:0] in_cls,
   output logic         evt_valid,
   input  logic         evt_ready,
   output logic         evt_set,
   output logic [C-1:0] evt_cls,
   output logic         fault_active,
   output logic [C-1:0] fault_cls,
   output logic         bad_cls,
   output logic         evt_overrun
);

   localparam int CNT_MAX = (CONFIRM_N > RELEASE_N) ? CONFIRM_N : RELEASE_N;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [C-1:0]  NORM     = NORMAL_CLS[C-1:0];
   localparam logic [C:0]    NUM_LIM  = NUM_CLS[C:0];
   localparam logic [CW-1:0] CONF_LIM = CONFIRM_N[CW-1:0];
   localparam logic [CW-1:0] REL_LIM  = RELEASE_N[CW-1:0];
   localparam logic [CW-1:0] CNT_TOP  = CNT_MAX[CW-1:0];
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [C-1:0]  cand_q, cand_d;
   logic          fault_active_q, fault_active_d;
   logic [C-1:0]  fault_cls_q, fault_cls_d;
   logic          bad_cls_q, bad_cls_d;

   logic          cls_legal;
   logic          cls_normal;
   logic [CW-1:0] cnt_inc;
   logic          raise;
   logic          raise_set;
   logic [C-1:0]  raise_cls;

   assign cls_legal  = ({1'b0, in_cls} < NUM_LIM);
   assign cls_normal = (in_cls == NORM);
   // Saturating increment so the counter can never wrap.
   assign cnt_inc    = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_ONE;

   // Debounce decision for one valid sample; out-of-range codes only flag bad_cls.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      cand_d         = cand_q;
      fault_active_d = fault_active_q;
      fault_cls_d    = fault_cls_q;
      bad_cls_d      = bad_cls_q;
      raise          = 1'b0;
      raise_set      = 1'b0;
      raise_cls      = NORM;
      if (in_valid) begin
         if (!cls_legal) begin
            bad_cls_d = 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (!cls_normal) begin
                     state_d = PENDING;
                     cand_d  = in_cls;
                     cnt_d   = CNT_ONE;
                  end
               end
               PENDING: begin
                  if (cls_normal) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     cand_d  = NORM;
                  end else if (in_cls == cand_q) begin
                     if (cnt_inc == CONF_LIM) begin
                        state_d        = CONFIRMED;
                        cnt_d          = '0;
                        fault_active_d = 1'b1;
                        fault_cls_d    = cand_q;
                        raise          = 1'b1;
                        raise_set      = 1'b1;
                        raise_cls      = cand_q;
                     end else begin
                        cnt_d = cnt_inc;
                     end
                  end else begin
                     cand_d = in_cls;
                     cnt_d  = CNT_ONE;
                  end
               end
               CONFIRMED: begin
                  // A different fault class never replaces the confirmed one.
                  if (cls_normal) begin
                     state_d = RELEASE;
                     cnt_d   = CNT_ONE;
                  end
               end
               RELEASE: begin
                  if (cls_normal) begin
                     if (cnt_inc == REL_LIM) begin
                        state_d        = IDLE;
                        cnt_d          = '0;
                        cand_d         = NORM;
                        fault_active_d = 1'b0;
                        fault_cls_d    = NORM;
                        raise          = 1'b1;
                        raise_set      = 1'b0;
                        raise_cls      = fault_cls_q;
                     end else begin
                        cnt_d = cnt_inc;
                     end
                  end else begin
                     state_d = CONFIRMED;
                     cnt_d   = '0;
                  end
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end
   end

   // FSM, counter and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         cand_q         <= NORM;
         fault_active_q <= 1'b0;
         fault_cls_q    <= NORM;
         bad_cls_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         cand_q         <= cand_d;
         fault_active_q <= fault_active_d;
         fault_cls_q    <= fault_cls_d;
         bad_cls_q      <= bad_cls_d;
      end
   end

   assign fault_active = fault_active_q;
   assign fault_cls    = fault_cls_q;
   assign bad_cls      = bad_cls_q;

   fault_evt_slot #(
      .C          (C),
      .NORMAL_CLS (NORMAL_CLS)
   ) u_evt_slot (
      .clk         (clk),
      .rst         (rst),
      .push        (raise),
      .push_set    (raise_set),
      .push_cls    (raise_cls),
      .evt_ready   (evt_ready),
      .evt_valid   (evt_valid),
      .evt_set     (evt_set),
      .evt_cls     (evt_cls),
      .evt_overrun (evt_overrun)
   );

endmodule

// File: tb/tb_fault_cls_confirm.sv
// Scoreboard bench for fault_cls_confirm with default parameters.
module tb_fault_cls_confirm;
   import fault_cls_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [2:0] in_cls;
   logic       evt_valid;
   logic       evt_ready;
   logic       evt_set;
   logic [2:0] evt_cls;
   logic       fault_active;
   logic [2:0] fault_cls;
   logic       bad_cls;
   logic       evt_overrun;

   int   n_checks = 0;
   int   n_fail   = 0;
   evt_t exp_q[$];
   evt_t exp_evt;
   logic       exp_fa;
   logic [2:0] exp_fc;

   fault_cls_confirm #(
      .C(3), .NUM_CLS(6), .NORMAL_CLS(0), .CONFIRM_N(4), .RELEASE_N(8)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_cls(in_cls),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_set(evt_set),
      .evt_cls(evt_cls), .fault_active(fault_active), .fault_cls(fault_cls),
      .bad_cls(bad_cls), .evt_overrun(evt_overrun)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; bit 3 set means an idle (in_valid=0) cycle.
   task automatic send(input logic [3:0] s);
      in_valid = ~s[3];
      in_cls   = s[2:0];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_cls = 3'd0; evt_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_fa = 1'b0; exp_fc = 3'd0;
      n_checks++;
      if ({evt_valid, evt_set, evt_cls} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_evt got v=%b s=%b c=%0d want 0/0/0", evt_valid, evt_set, evt_cls);
      end
      n_checks++;
      if ({fault_active, fault_cls, bad_cls, evt_overrun} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_status got fa=%b fc=%0d bad=%b ovr=%b want all 0",
                  fault_active, fault_cls, bad_cls, evt_overrun);
      end
   endtask

   task automatic test_normal_idle();
      for (int i = 0; i < 10; i++) begin
         send(4'd0);
         n_checks++;
         if ({evt_valid, fault_active, fault_cls} !== 5'b0) begin
            n_fail++;
            $display("FAIL normal_idle step=%0d got v=%b fa=%b fc=%0d want 0/0/0",
                     i, evt_valid, fault_active, fault_cls);
         end
      end
   endtask

   task automatic test_confirm();
      logic [3:0] seq[$] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd8,
                             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      int         ev_idx[2] = '{3, 12};
      logic [3:0] ev_val[2] = '{4'b1011, 4'b0011};
      for (int i = 0; i < seq.size(); i++) begin
         for (int k = 0; k < 2; k++)
            if (i == ev_idx[k]) exp_q.push_back(evt_t'(ev_val[k]));
         send(seq[i]);
         n_checks++;
         if (exp_q.size() != 0) begin
            exp_evt = exp_q.pop_front();
            exp_fa  = exp_evt.set;
            exp_fc  = exp_evt.set ? exp_evt.cls : 3'd0;
            if ({evt_valid, evt_set, evt_cls} !== {1'b1, exp_evt.set, exp_evt.cls}) begin
               n_fail++;
               $display("FAIL confirm_evt step=%0d got v=%b s=%b c=%0d want v=1 s=%b c=%0d",
                        i, evt_valid, evt_set, evt_cls, exp_evt.set, exp_evt.cls);
            end
         end else if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL confirm_noevt step=%0d got v=%b want v=0", i, evt_valid);
         end
         n_checks++;
         if ({fault_active, fault_cls} !== {exp_fa, exp_fc}) begin
            n_fail++;
            $display("FAIL confirm_status step=%0d got fa=%b fc=%0d want fa=%b fc=%0d",
                     i, fault_active, fault_cls, exp_fa, exp_fc);
         end
      end
   endtask

   task automatic test_restart();
      logic [3:0] seq[$] = '{4'd3, 4'd3, 4'd0, 4'd3, 4'd3, 4'd5, 4'd5, 4'd5, 4'd5,
                             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      int         ev_idx[2] = '{8, 16};
      logic [3:0] ev_val[2] = '{4'b1101, 4'b0101};
      for (int i = 0; i < seq.size(); i++) begin
         for (int k = 0; k < 2; k++)
            if (i == ev_idx[k]) exp_q.push_back(evt_t'(ev_val[k]));
         send(seq[i]);
         n_checks++;
         if (exp_q.size() != 0) begin
            exp_evt = exp_q.pop_front();
            exp_fa  = exp_evt.set;
            exp_fc  = exp_evt.set ? exp_evt.cls : 3'd0;
            if ({evt_valid, evt_set, evt_cls} !== {1'b1, exp_evt.set, exp_evt.cls}) begin
               n_fail++;
               $display("FAIL restart_evt step=%0d got v=%b s=%b c=%0d want v=1 s=%b c=%0d",
                        i, evt_valid, evt_set, evt_cls, exp_evt.set, exp_evt.cls);
            end
         end else if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_noevt step=%0d got v=%b want v=0", i, evt_valid);
         end
         n_checks++;
         if ({fault_active, fault_cls} !== {exp_fa, exp_fc}) begin
            n_fail++;
            $display("FAIL restart_status step=%0d got fa=%b fc=%0d want fa=%b fc=%0d",
                     i, fault_active, fault_cls, exp_fa, exp_fc);
         end
      end
   endtask

   task automatic test_release_abort();
      logic [3:0] seq[$] = '{4'd2, 4'd2, 4'd2, 4'd2,
                             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4,
                             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      int         ev_idx[2] = '{3, 19};
      logic [3:0] ev_val[2] = '{4'b1010, 4'b0010};
      for (int i = 0; i < seq.size(); i++) begin
         for (int k = 0; k < 2; k++)
            if (i == ev_idx[k]) exp_q.push_back(evt_t'(ev_val[k]));
         send(seq[i]);
         n_checks++;
         if (exp_q.size() != 0) begin
            exp_evt = exp_q.pop_front();
            exp_fa  = exp_evt.set;
            exp_fc  = exp_evt.set ? exp_evt.cls : 3'd0;
            if ({evt_valid, evt_set, evt_cls} !== {1'b1, exp_evt.set, exp_evt.cls}) begin
               n_fail++;
               $display("FAIL abort_evt step=%0d got v=%b s=%b c=%0d want v=1 s=%b c=%0d",
                        i, evt_valid, evt_set, evt_cls, exp_evt.set, exp_evt.cls);
            end
         end else if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_noevt step=%0d got v=%b want v=0", i, evt_valid);
         end
         n_checks++;
         if ({fault_active, fault_cls} !== {exp_fa, exp_fc}) begin
            n_fail++;
            $display("FAIL abort_status step=%0d got fa=%b fc=%0d want fa=%b fc=%0d",
                     i, fault_active, fault_cls, exp_fa, exp_fc);
         end
      end
   endtask

   task automatic test_bad_cls();
      logic [3:0] seq[$] = '{4'd3, 4'd3, 4'd7, 4'd6, 4'd3, 4'd3,
                             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      int         ev_idx[2] = '{5, 13};
      logic [3:0] ev_val[2] = '{4'b1011, 4'b0011};
      n_checks++;
      if (bad_cls !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_cls_before got=%b want=0", bad_cls);
      end
      for (int i = 0; i < seq.size(); i++) begin
         for (int k = 0; k < 2; k++)
            if (i == ev_idx[k]) exp_q.push_back(evt_t'(ev_val[k]));
         send(seq[i]);
         n_checks++;
         if (exp_q.size() != 0) begin
            exp_evt = exp_q.pop_front();
            exp_fa  = exp_evt.set;
            exp_fc  = exp_evt.set ? exp_evt.cls : 3'd0;
            if ({evt_valid, evt_set, evt_cls} !== {1'b1, exp_evt.set, exp_evt.cls}) begin
               n_fail++;
               $display("FAIL bad_cls_evt step=%0d got v=%b s=%b c=%0d want v=1 s=%b c=%0d",
                        i, evt_valid, evt_set, evt_cls, exp_evt.set, exp_evt.cls);
            end
         end else if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_cls_noevt step=%0d got v=%b want v=0", i, evt_valid);
         end
         n_checks++;
         if (bad_cls !== (i >= 2)) begin
            n_fail++;
            $display("FAIL bad_cls_flag step=%0d got=%b want=%b", i, bad_cls, (i >= 2));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] seq[$] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      int         ev_idx[2] = '{3, -1};
      logic [3:0] ev_val[2] = '{4'b1100, 4'b0000};
      send(4'd4);
      send(4'd4);
      // Reset together with a sample that would otherwise advance PENDING.
      rst = 1'b1; in_valid = 1'b1; in_cls = 3'd4;
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      exp_fa = 1'b0; exp_fc = 3'd0;
      n_checks++;
      if ({evt_valid, fault_active, bad_cls, evt_overrun} !== 4'b0) begin
         n_fail++;
         $display("FAIL rst_pending got v=%b fa=%b bad=%b ovr=%b want all 0",
                  evt_valid, fault_active, bad_cls, evt_overrun);
      end
      for (int i = 0; i < seq.size(); i++) begin
         for (int k = 0; k < 2; k++)
            if (i == ev_idx[k]) exp_q.push_back(evt_t'(ev_val[k]));
         send(seq[i]);
         n_checks++;
         if (exp_q.size() != 0) begin
            exp_evt = exp_q.pop_front();
            exp_fa  = exp_evt.set;
            exp_fc  = exp_evt.set ? exp_evt.cls : 3'd0;
            if ({evt_valid, evt_set, evt_cls} !== {1'b1, exp_evt.set, exp_evt.cls}) begin
               n_fail++;
               $display("FAIL rstmid_evt step=%0d got v=%b s=%b c=%0d want v=1 s=%b c=%0d",
                        i, evt_valid, evt_set, evt_cls, exp_evt.set, exp_evt.cls);
            end
         end else if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_noevt step=%0d got v=%b want v=0", i, evt_valid);
         end
         n_checks++;
         if ({fault_active, fault_cls} !== {exp_fa, exp_fc}) begin
            n_fail++;
            $display("FAIL rstmid_status step=%0d got fa=%b fc=%0d want fa=%b fc=%0d",
                     i, fault_active, fault_cls, exp_fa, exp_fc);
         end
      end
      // Reset together with the eighth normal sample of a release.
      rst = 1'b1; in_valid = 1'b1; in_cls = 3'd0;
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      exp_fa = 1'b0; exp_fc = 3'd0;
      n_checks++;
      if ({evt_valid, evt_cls, fault_active, fault_cls} !== 8'b0) begin
         n_fail++;
         $display("FAIL rst_release got v=%b c=%0d fa=%b fc=%0d want all 0",
                  evt_valid, evt_cls, fault_active, fault_cls);
      end
   endtask

   task automatic test_accept_replace();
      evt_ready = 1'b0;
      exp_q.push_back(evt_t'(4'b1100));
      repeat (4) send(4'd4);
      repeat (7) send(4'd0);
      exp_evt = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_set, evt_cls} !== {1'b1, exp_evt.set, exp_evt.cls}) begin
         n_fail++;
         $display("FAIL hold_evt got v=%b s=%b c=%0d want v=1 s=%b c=%0d",
                  evt_valid, evt_set, evt_cls, exp_evt.set, exp_evt.cls);
      end
      // Accept the held event in the same cycle the clear event is raised.
      evt_ready = 1'b1;
      exp_q.push_back(evt_t'(4'b0100));
      send(4'd0);
      exp_evt = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_set, evt_cls, evt_overrun} !== {1'b1, exp_evt.set, exp_evt.cls, 1'b0}) begin
         n_fail++;
         $display("FAIL replace_evt got v=%b s=%b c=%0d ovr=%b want v=1 s=%b c=%0d ovr=0",
                  evt_valid, evt_set, evt_cls, evt_overrun, exp_evt.set, exp_evt.cls);
      end
      send(4'd8);
      n_checks++;
      if (evt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL replace_drop got v=%b want v=0", evt_valid);
      end
   endtask

   task automatic test_overrun();
      evt_ready = 1'b0;
      exp_q.push_back(evt_t'(4'b1001));
      repeat (4) send(4'd1);
      exp_evt = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_set, evt_cls, evt_overrun} !== {1'b1, exp_evt.set, exp_evt.cls, 1'b0}) begin
         n_fail++;
         $display("FAIL ovr_first got v=%b s=%b c=%0d ovr=%b want v=1 s=%b c=%0d ovr=0",
                  evt_valid, evt_set, evt_cls, evt_overrun, exp_evt.set, exp_evt.cls);
      end
      exp_q.push_back(evt_t'(4'b0001));
      repeat (8) send(4'd0);
      exp_evt = exp_q.pop_front();
      n_checks++;
      if ({evt_valid, evt_set, evt_cls, evt_overrun} !== {1'b1, exp_evt.set, exp_evt.cls, 1'b1}) begin
         n_fail++;
         $display("FAIL ovr_second got v=%b s=%b c=%0d ovr=%b want v=1 s=%b c=%0d ovr=1",
                  evt_valid, evt_set, evt_cls, evt_overrun, exp_evt.set, exp_evt.cls);
      end
      evt_ready = 1'b1;
      send(4'd8);
      n_checks++;
      if ({evt_valid, evt_overrun, fault_active} !== 3'b010) begin
         n_fail++;
         $display("FAIL ovr_after got v=%b ovr=%b fa=%b want v=0 ovr=1 fa=0",
                  evt_valid, evt_overrun, fault_active);
      end
   endtask

   initial begin
      test_reset();
      test_normal_idle();
      test_confirm();
      test_restart();
      test_release_abort();
      test_bad_cls();
      test_reset_mid();
      test_accept_replace();
      test_overrun();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fault_cls_confirm.md
Name: fault_cls_confirm

Overview:
- Downstream stage of the combinational decision-tree fault classifier.
- Consumes one 3-bit class code per valid sample and debounces it over consecutive samples.
- Declares a confirmed fault only after CONFIRM_N identical fault-class samples, and clears it after RELEASE_N consecutive normal samples.
- Reports set/clear events to the protection controller over a valid/ready interface and holds a level-type fault status.

Parameters:
- C, 3, width of class code.
- NUM_CLS, 6, number of legal class codes (0..NUM_CLS-1).
- NORMAL_CLS, 0, class code meaning "no fault".
- CONFIRM_N, 4, consecutive identical fault samples needed to confirm (legal range >= 2).
- RELEASE_N, 8, consecutive normal samples needed to clear (legal range >= 2).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_cls is a new classifier sample this cycle.
- in_cls  in  C  class code from the classifier.
- evt_valid  out  1  event pending.
- evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready.
- evt_set  out  1  1 = fault confirmed, 0 = fault cleared.
- evt_cls  out  C  class associated with the event.
- fault_active  out  1  level: a confirmed fault is in force.
- fault_cls  out  C  confirmed class; NORMAL_CLS when fault_active=0.
- bad_cls  out  1  sticky: an out-of-range in_cls was seen.
- evt_overrun  out  1  sticky: an unaccepted event was overwritten.

Behaviour:
- Reset values: all outputs 0, except fault_cls = NORMAL_CLS and evt_cls = NORMAL_CLS. State = IDLE, counter = 0, candidate = NORMAL_CLS.
- Reset wins over every other event in the same cycle, including mid-PENDING and mid-RELEASE; no event is emitted.
- Only cycles with in_valid=1 are evaluated; all state is held otherwise.
- Sample with in_cls >= NUM_CLS: sets bad_cls and is otherwise ignored (no state or counter change).
- Counter width is clog2(max(CONFIRM_N, RELEASE_N)+1), and the counter never wraps.
- States are IDLE, PENDING, CONFIRMED and RELEASE.
- IDLE: a fault sample (!= NORMAL_CLS) moves to PENDING with candidate = in_cls and cnt = 1. A normal sample stays in IDLE.
- PENDING, sample == candidate:
  - cnt++.
  - When cnt reaches CONFIRM_N, go to CONFIRMED, set fault_active = 1 and fault_cls = candidate, and raise the event {set=1, cls=candidate}.
- PENDING, different fault class: candidate = in_cls, cnt = 1 (restart).
- PENDING, normal sample: go to IDLE, cnt = 0, no event.
- CONFIRMED:
  - A normal sample moves to RELEASE with cnt = 1.
  - A different fault class is ignored; the first confirmed class holds until release.
- RELEASE:
  - A normal sample does cnt++. When cnt reaches RELEASE_N, go to IDLE, set fault_active = 0 and fault_cls = NORMAL_CLS, and raise the event {set=0, cls=previous fault_cls}.
  - Any legal fault sample returns to CONFIRMED with cnt = 0 and no event.
- Latency: fault_active, fault_cls and evt_valid update on the clock edge that samples the deciding in_valid, so they are visible the next cycle.
- Event handshake:
  - evt_valid, evt_set and evt_cls stay stable until accepted; on acceptance evt_valid drops the next cycle.
  - If a new event is raised while evt_valid=1 and not accepted in that cycle, the new event overwrites the old one and evt_overrun is set.
  - If the old event is accepted in the same cycle, the new event simply replaces it with no overrun.
- bad_cls and evt_overrun clear only on rst.

Decomposition:
- Package fault_cls_pkg:
  - state enum (IDLE, PENDING, CONFIRMED, RELEASE).
  - localparams for the default NUM_CLS and NORMAL_CLS.
  - a packed event struct {set, cls}.
- One sub-module is natural: fault_evt_slot, a single-entry event holding register with valid/ready, overwrite and overrun flag. The FSM and counter stay in the top module.

Test Plan (defaults):
- Reset, then 10 samples of cls 0 -> no event; fault_active=0; fault_cls=0.
- Samples 3,3,3,3 -> evt_valid=1, evt_set=1, evt_cls=3 the cycle after the 4th sample; fault_active=1, fault_cls=3. With evt_ready=1, evt_valid drops next cycle.
- Samples 3,3,0,3,3,5,5,5,5 -> no event until the 4th 5, then event {1,5}. The 0 and the class change each restart the count.
- After confirming class 2: samples 0x7 then 4 then 0x8 -> first release aborted (back to CONFIRMED); the release completes on the 8th 0 with event {0,2}, fault_active=0.
- Hold evt_ready=0, confirm class 1 and then release it -> evt_overrun=1; pending event = {0,1}.
- in_cls=7 with in_valid=1 in PENDING -> bad_cls=1; cnt and candidate unchanged. Also assert rst mid-PENDING -> state IDLE, no event.
